// File: rtl/axi4_burst_master_pkg.sv
// Shared FSM state type, AXI encodings and the beat data pattern used by axi4_burst_master.
package axi4_burst_master_pkg;

  localparam int unsigned IDX_W = 9;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;
  localparam logic [1:0] RESP_DECERR   = 2'b11;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } state_e;

  // Beat k carries base + 4*k + 1; callers truncate to their data width.
  function automatic logic [127:0] expected_data(input logic [63:0] base,
                                                 input logic [IDX_W-1:0] k);
    logic [63:0] sum;
    sum = base + {53'd0, k, 2'b00} + 64'd1;
    return {64'd0, sum};
  endfunction

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi4_burst_master_if.sv
// AXI4 full bus bundle with master and slave views.
interface axi4_burst_master_if #(
  parameter int ID_WIDTH     = 1,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int AWUSER_WIDTH = 1,
  parameter int ARUSER_WIDTH = 1,
  parameter int WUSER_WIDTH  = 1,
  parameter int RUSER_WIDTH  = 1,
  parameter int BUSER_WIDTH  = 1
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [AWUSER_WIDTH-1:0] awuser;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic [WUSER_WIDTH-1:0]  wuser;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic [BUSER_WIDTH-1:0]  buser;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [ARUSER_WIDTH-1:0] aruser;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [RUSER_WIDTH-1:0]  ruser;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_beat_counter.sv
// Per-burst beat counter; 9 bits so a full 256-beat burst is representable without wrapping.
module axi4_beat_counter
  import axi4_burst_master_pkg::*;
#(
  parameter int unsigned BURST_LEN = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             incr_i,
  output logic [IDX_W-1:0] count_o,
  output logic             last_o
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] MAX_CNT  = IDX_W'(256);

  logic [IDX_W-1:0] count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (incr_i && (count_q != MAX_CNT)) begin
      count_q <= count_q + IDX_W'(1);
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == LAST_IDX);
endmodule

// File: rtl/axi4_burst_master.sv
// Single-burst AXI4 master: one INCR write or read per init_txn rising edge, with done/error sideband.
// Define AXI4_BURST_MASTER_RDATA_CHECK_EN to also flag read data that differs from the write pattern.
module axi4_burst_master
  import axi4_burst_master_pkg::*;
#(
  parameter int                  ID_WIDTH     = 1,
  parameter int                  ADDR_WIDTH   = 32,
  parameter int                  DATA_WIDTH   = 32,
  parameter int                  AWUSER_WIDTH = 1,
  parameter int                  ARUSER_WIDTH = 1,
  parameter int                  WUSER_WIDTH  = 1,
  parameter int                  RUSER_WIDTH  = 1,
  parameter int                  BUSER_WIDTH  = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned         BURST_LEN    = 1,
  parameter int unsigned         OP_TYPE      = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                init_txn,
  output logic                txn_done,
  output logic                error,
  output logic [IDX_W-1:0]    write_index,
  output logic [IDX_W-1:0]    read_index,
  axi4_burst_master_if.master m_axi
);
  localparam logic [7:0] AXLEN  = 8'(BURST_LEN - 1);
  localparam logic [2:0] AXSIZE = 3'($clog2(DATA_WIDTH / 8));

  state_e state_q;
  logic   init_q, awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, txn_done_q, error_q;
  logic   start, start_accept, w_hs, r_hs, rdata_bad, r_fault;

  logic [1:0]       beat_incr, beat_last;
  logic [IDX_W-1:0] beat_count [2];

  assign start        = init_txn & ~init_q;
  assign start_accept = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign w_hs         = wvalid_q & m_axi.wready;
  assign r_hs         = rready_q & m_axi.rvalid;
  assign beat_incr    = {r_hs, w_hs};

  // Index 0 counts W beats, index 1 counts R beats.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    axi4_beat_counter #(.BURST_LEN(BURST_LEN)) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .clear_i (start_accept),
      .incr_i  (beat_incr[gi]),
      .count_o (beat_count[gi]),
      .last_o  (beat_last[gi])
    );
  end

  assign write_index = beat_count[0];
  assign read_index  = beat_count[1];

`ifdef AXI4_BURST_MASTER_RDATA_CHECK_EN
  assign rdata_bad = (m_axi.rdata != DATA_WIDTH'(expected_data(64'(BASE_ADDR), read_index)));
  logic unused_in;
  assign unused_in = ^{m_axi.bid, m_axi.buser, m_axi.bresp[0], m_axi.rid, m_axi.ruser, m_axi.rresp[0]};
`else
  assign rdata_bad = 1'b0;
  logic unused_in;
  assign unused_in = ^{m_axi.bid, m_axi.buser, m_axi.bresp[0], m_axi.rid, m_axi.ruser,
                       m_axi.rresp[0], m_axi.rdata};
`endif

  // rlast must coincide exactly with the final beat; early or missing rlast is a fault.
  assign r_fault = resp_is_err(m_axi.rresp) | (m_axi.rlast != beat_last[1]) | rdata_bad;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      init_q     <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      txn_done_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      init_q <= init_txn;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            txn_done_q <= 1'b0;
            error_q    <= 1'b0;
            state_q    <= (OP_TYPE != 0) ? ST_RD_ADDR : ST_WR_ADDR;
          end
        end
        ST_WR_ADDR: begin
          if (awvalid_q && m_axi.awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            state_q   <= ST_WR_DATA;
          end else begin
            awvalid_q <= 1'b1;
          end
        end
        ST_WR_DATA: begin
          if (w_hs && beat_last[0]) begin
            wvalid_q <= 1'b0;
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (m_axi.bvalid && bready_q) begin
            bready_q   <= 1'b0;
            txn_done_q <= 1'b1;
            state_q    <= ST_DONE;
            if (resp_is_err(m_axi.bresp)) error_q <= 1'b1;
          end
        end
        ST_RD_ADDR: begin
          if (arvalid_q && m_axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_DATA;
          end else begin
            arvalid_q <= 1'b1;
          end
        end
        ST_RD_DATA: begin
          if (r_hs) begin
            if (r_fault) error_q <= 1'b1;
            if (m_axi.rlast || beat_last[1]) begin
              rready_q   <= 1'b0;
              txn_done_q <= 1'b1;
              state_q    <= ST_DONE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign txn_done = txn_done_q;
  assign error    = error_q;

  assign m_axi.awid    = '0;
  assign m_axi.awaddr  = BASE_ADDR;
  assign m_axi.awlen   = AXLEN;
  assign m_axi.awsize  = AXSIZE;
  assign m_axi.awburst = BURST_INCR;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = CACHE_DEFAULT;
  assign m_axi.awprot  = '0;
  assign m_axi.awqos   = '0;
  assign m_axi.awuser  = '0;
  assign m_axi.awvalid = awvalid_q;

  assign m_axi.wdata  = DATA_WIDTH'(expected_data(64'(BASE_ADDR), write_index));
  assign m_axi.wstrb  = '1;
  assign m_axi.wlast  = beat_last[0];
  assign m_axi.wuser  = '0;
  assign m_axi.wvalid = wvalid_q;
  assign m_axi.bready = bready_q;

  assign m_axi.arid    = '0;
  assign m_axi.araddr  = BASE_ADDR;
  assign m_axi.arlen   = AXLEN;
  assign m_axi.arsize  = AXSIZE;
  assign m_axi.arburst = BURST_INCR;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = CACHE_DEFAULT;
  assign m_axi.arprot  = '0;
  assign m_axi.arqos   = '0;
  assign m_axi.aruser  = '0;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench: four master configurations (read x1, write x4, write x256, read x8) against simple slave models.
module tb_axi4_burst_master;
  import axi4_burst_master_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [3:0]      init_txn;
  logic [3:0]      txn_done;
  logic [3:0]      error_o;
  logic [3:0][8:0] widx;
  logic [3:0][8:0] ridx;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int OP_T  [4] = '{1, 0, 0, 1};
  localparam int LEN_T [4] = '{1, 4, 256, 8};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int LEN = LEN_T[gi];
    localparam int OPT = OP_T[gi];

    axi4_burst_master_if bus ();

    axi4_burst_master #(.OP_TYPE(OPT), .BURST_LEN(LEN)) u_dut (
      .clock       (clock),
      .reset       (reset),
      .init_txn    (init_txn[gi]),
      .txn_done    (txn_done[gi]),
      .error       (error_o[gi]),
      .write_index (widx[gi]),
      .read_index  (ridx[gi]),
      .m_axi       (bus.master)
    );

    logic [1:0]  bresp_cfg = RESP_OKAY;
    int          rlast_cfg = LEN - 1;
    bit          wrand     = (gi == 2);
    int          wbeats = 0, rbeats = 0, aw_cnt = 0, ar_cnt = 0;
    bit          aw_seen = 0, b_pend = 0, b_hs = 0, r_active = 0;
    logic [31:0] wlog [256];

    // Slave model: decides ready/valid at each falling edge, so a handshake seen here completes on the next rising edge.
    initial begin
      bus.awready = 1'b0; bus.wready = 1'b0;
      bus.bvalid = 1'b0; bus.bid = '0; bus.bresp = '0; bus.buser = '0;
      bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rid = '0; bus.rdata = '0;
      bus.rresp = '0; bus.rlast = 1'b0; bus.ruser = '0;
      forever begin
        @(negedge clock);
        if (!reset) begin
          bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
          bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0;
          aw_seen = 0; b_pend = 0; b_hs = 0; r_active = 0;
          wbeats = 0; rbeats = 0; aw_cnt = 0; ar_cnt = 0;
        end else begin
          bus.awready = 1'b1;
          if (bus.awvalid) begin
            aw_cnt++; aw_seen = 1; wbeats = 0;
            check($sformatf("u%0d_awaddr", gi), 64'(bus.awaddr), 64'h8000_0000);
            check($sformatf("u%0d_awlen", gi), 64'(bus.awlen), 64'(LEN - 1));
            check($sformatf("u%0d_awsize", gi), 64'(bus.awsize), 64'd2);
            check($sformatf("u%0d_awburst", gi), 64'(bus.awburst), 64'd1);
            check($sformatf("u%0d_awcache", gi), 64'(bus.awcache), 64'd3);
          end
          if (b_hs) begin
            bus.bvalid = 1'b0; b_hs = 0; aw_seen = 0;
          end
          if (b_pend) begin
            bus.bvalid = 1'b1; bus.bresp = bresp_cfg; b_pend = 0;
          end
          if (bus.bvalid && bus.bready) b_hs = 1;

          bus.wready = wrand ? 1'($urandom_range(0, 1)) : 1'b1;
          if (bus.wvalid && bus.wready) begin
            check($sformatf("u%0d_w_after_aw", gi), 64'(aw_seen), 64'd1);
            check($sformatf("u%0d_wdata", gi), 64'(bus.wdata), 64'(32'h8000_0001 + 32'(4 * wbeats)));
            check($sformatf("u%0d_wlast", gi), 64'(bus.wlast), 64'(wbeats == LEN - 1));
            check($sformatf("u%0d_wstrb", gi), 64'(bus.wstrb), 64'hF);
            if (wbeats < 256) wlog[8'(wbeats)] = bus.wdata;
            wbeats++;
            if (bus.wlast) b_pend = 1;
          end

          bus.rvalid = r_active;
          bus.rdata  = 32'h8000_0001 + 32'(4 * rbeats);
          bus.rlast  = r_active && (rbeats == rlast_cfg);
          bus.rresp  = RESP_OKAY;
          if (bus.rvalid && bus.rready) begin
            rbeats++;
            if (bus.rlast || rbeats == LEN) r_active = 0;
          end

          bus.arready = 1'b1;
          if (bus.arvalid) begin
            ar_cnt++; r_active = 1; rbeats = 0;
            check($sformatf("u%0d_araddr", gi), 64'(bus.araddr), 64'h8000_0000);
            check($sformatf("u%0d_arlen", gi), 64'(bus.arlen), 64'(LEN - 1));
            check($sformatf("u%0d_arsize", gi), 64'(bus.arsize), 64'd2);
            check($sformatf("u%0d_arburst", gi), 64'(bus.arburst), 64'd1);
          end
        end
      end
    end
  end

  task automatic pulse(input int gi);
    init_txn[gi] = 1'b1;
    @(negedge clock);
    @(negedge clock);
    init_txn[gi] = 1'b0;
    check($sformatf("u%0d_done_cleared", gi), 64'(txn_done[gi]), 64'd0);
    check($sformatf("u%0d_err_cleared", gi), 64'(error_o[gi]), 64'd0);
  endtask

  task automatic wait_done(input int gi, input int budget);
    int c = 0;
    while (!txn_done[gi] && c < budget) begin
      @(negedge clock);
      c++;
    end
    check($sformatf("u%0d_txn_done", gi), 64'(txn_done[gi]), 64'd1);
  endtask

  logic [31:0] wtab [4];

  initial begin
    wtab[0] = 32'h8000_0001; wtab[1] = 32'h8000_0005;
    wtab[2] = 32'h8000_0009; wtab[3] = 32'h8000_000D;
    reset    = 1'b0;
    init_txn = '0;
    @(negedge clock);
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_done%0d", i), 64'(txn_done[i]), 64'd0);
      check($sformatf("rst_err%0d", i), 64'(error_o[i]), 64'd0);
      check($sformatf("rst_widx%0d", i), 64'(widx[i]), 64'd0);
      check($sformatf("rst_ridx%0d", i), 64'(ridx[i]), 64'd0);
    end
    check("rst_arvalid0", 64'(g_dut[0].bus.arvalid), 64'd0);
    check("rst_rready0", 64'(g_dut[0].bus.rready), 64'd0);
    check("rst_awvalid1", 64'(g_dut[1].bus.awvalid), 64'd0);
    check("rst_wvalid1", 64'(g_dut[1].bus.wvalid), 64'd0);
    check("rst_bready1", 64'(g_dut[1].bus.bready), 64'd0);
    reset = 1'b1;

    // Single-beat read
    pulse(0);
    wait_done(0, 50);
    check("rd1_ridx", 64'(ridx[0]), 64'd1);
    check("rd1_err", 64'(error_o[0]), 64'd0);
    check("rd1_ar_cnt", 64'(g_dut[0].ar_cnt), 64'd1);
    repeat (5) @(negedge clock);
    check("rd1_done_held", 64'(txn_done[0]), 64'd1);

    // Four-beat write, OKAY
    pulse(1);
    wait_done(1, 100);
    check("wr4_widx", 64'(widx[1]), 64'd4);
    check("wr4_beats", 64'(g_dut[1].wbeats), 64'd4);
    check("wr4_err", 64'(error_o[1]), 64'd0);
    for (int k = 0; k < 4; k++)
      check($sformatf("wr4_wdata%0d", k), 64'(g_dut[1].wlog[k]), 64'(wtab[k]));

    // SLVERR write, then a clean repeat clears the error
    g_dut[1].bresp_cfg = RESP_SLVERR;
    pulse(1);
    wait_done(1, 100);
    check("wr4_slverr_err", 64'(error_o[1]), 64'd1);
    g_dut[1].bresp_cfg = RESP_OKAY;
    pulse(1);
    wait_done(1, 100);
    check("wr4_repeat_err", 64'(error_o[1]), 64'd0);
    check("wr4_repeat_widx", 64'(widx[1]), 64'd4);
    check("wr4_aw_cnt", 64'(g_dut[1].aw_cnt), 64'd3);

    // 256-beat write with random wready
    pulse(2);
    wait_done(2, 3000);
    check("wr256_widx", 64'(widx[2]), 64'd256);
    check("wr256_beats", 64'(g_dut[2].wbeats), 64'd256);
    check("wr256_err", 64'(error_o[2]), 64'd0);

    // Eight-beat read with rlast on the 5th beat
    g_dut[3].rlast_cfg = 4;
    pulse(3);
    wait_done(3, 200);
    check("rd8_early_err", 64'(error_o[3]), 64'd1);
    check("rd8_early_ridx", 64'(ridx[3]), 64'd5);
    check("rd8_early_beats", 64'(g_dut[3].rbeats), 64'd5);
    // rlast never asserted
    g_dut[3].rlast_cfg = 100;
    pulse(3);
    wait_done(3, 200);
    check("rd8_norlast_err", 64'(error_o[3]), 64'd1);
    check("rd8_norlast_ridx", 64'(ridx[3]), 64'd8);
    // Clean read
    g_dut[3].rlast_cfg = 7;
    pulse(3);
    wait_done(3, 200);
    check("rd8_ok_err", 64'(error_o[3]), 64'd0);
    check("rd8_ok_ridx", 64'(ridx[3]), 64'd8);

    // Reset in the middle of a 256-beat write
    pulse(2);
    for (int c = 0; c < 500 && widx[2] < 9'd20; c++) @(negedge clock);
    check("mid_reached", 64'(widx[2] >= 9'd20), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_wvalid", 64'(g_dut[2].bus.wvalid), 64'd0);
    check("mid_rst_awvalid", 64'(g_dut[2].bus.awvalid), 64'd0);
    check("mid_rst_bready", 64'(g_dut[2].bus.bready), 64'd0);
    check("mid_rst_widx", 64'(widx[2]), 64'd0);
    check("mid_rst_done2", 64'(txn_done[2]), 64'd0);
    check("mid_rst_done0", 64'(txn_done[0]), 64'd0);
    check("mid_rst_err3", 64'(error_o[3]), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    pulse(2);
    wait_done(2, 3000);
    check("mid_rerun_widx", 64'(widx[2]), 64'd256);
    check("mid_rerun_beats", 64'(g_dut[2].wbeats), 64'd256);
    check("mid_rerun_err", 64'(error_o[2]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
